// File: rtl/oscilo_pkg.sv
// Shared oscilloscope definitions: capture depth, frame header bytes and the
// readout FSM state encoding. Also used by the sampler.
package oscilo_pkg;

    localparam int unsigned SAMPLE_DEPTH_DEF = 8;
    localparam logic [7:0]  HDR0_DEF         = 8'hA5;
    localparam logic [7:0]  HDR1_DEF         = 8'h5A;

    // Readout frame sequencer states
    typedef enum logic [2:0] {
        RD_IDLE,
        RD_HDR0,
        RD_HDR1,
        RD_FETCH,
        RD_LOAD,
        RD_SEND,
        RD_CSUM,
        RD_FINISH
    } readout_state_t;

endpackage

// File: rtl/sample_readout.sv
// sample_readout: streams a completed capture out of the sample RAM as a
// UART frame: HDR0, HDR1, 2^SAMPLE_DEPTH samples oldest-first (the trigger
// sample lands at the middle index), then an 8-bit checksum of the samples.
//
// Ports
//   clk_50mhz    in   sole clock, rising edge
//   reset        in   synchronous active-high reset
//   start        in   one-cycle request to read out a capture (IDLE only)
//   trig_offset  in   RAM address holding the trigger sample
//   busy         out  frame in progress
//   done         out  one-cycle pulse after the checksum byte is accepted
//   mem_addr     out  registered capture RAM read address
//   mem_rd_data  in   RAM read data, valid one cycle after mem_addr
//   tx_data      out  byte offered to the UART
//   tx_valid     out  tx_data is valid
//   tx_ready     in   UART accepts; transfer when tx_valid && tx_ready
module sample_readout
    import oscilo_pkg::*;
#(
    parameter int unsigned SAMPLE_DEPTH = SAMPLE_DEPTH_DEF,
    parameter logic [7:0]  HDR0         = HDR0_DEF,
    parameter logic [7:0]  HDR1         = HDR1_DEF
) (
    input  logic                    clk_50mhz,
    input  logic                    reset,
    input  logic                    start,
    input  logic [SAMPLE_DEPTH-1:0] trig_offset,
    output logic                    busy,
    output logic                    done,
    output logic [SAMPLE_DEPTH-1:0] mem_addr,
    input  logic [7:0]              mem_rd_data,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready
);

    // Half the buffer: oldest sample sits this far from the trigger sample
    localparam logic [SAMPLE_DEPTH-1:0] PTR_HALF = {1'b1, {(SAMPLE_DEPTH-1){1'b0}}};
    localparam logic [SAMPLE_DEPTH-1:0] LAST_CNT = '1;
    localparam logic [SAMPLE_DEPTH-1:0] ONE      = SAMPLE_DEPTH'(1);

    readout_state_t          r_state;
    logic [SAMPLE_DEPTH-1:0] r_rd_ptr;
    logic [SAMPLE_DEPTH-1:0] r_count;
    logic [7:0]              r_csum;
    logic [7:0]              r_tx_data;
    logic                    r_tx_valid;
    logic                    r_busy;
    logic                    r_done;
    logic [SAMPLE_DEPTH-1:0] r_mem_addr;

    readout_state_t          w_state_nxt;
    logic [SAMPLE_DEPTH-1:0] w_rd_ptr_nxt;
    logic [SAMPLE_DEPTH-1:0] w_count_nxt;
    logic [7:0]              w_csum_nxt;
    logic [7:0]              w_tx_data_nxt;
    logic                    w_tx_valid_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;
    logic [SAMPLE_DEPTH-1:0] w_mem_addr_nxt;

    logic                    w_xfer;
    logic [7:0]              w_csum_add;

    assign w_xfer     = r_tx_valid & tx_ready;
    assign w_csum_add = r_csum + r_tx_data;

    // State and registered outputs
    always_ff @(posedge clk_50mhz) begin
        if (reset) begin
            r_state    <= RD_IDLE;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_csum     <= '0;
            r_tx_data  <= '0;
            r_tx_valid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rd_ptr   <= w_rd_ptr_nxt;
            r_count    <= w_count_nxt;
            r_csum     <= w_csum_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_tx_valid <= w_tx_valid_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_mem_addr <= w_mem_addr_nxt;
        end
    end

    // Next state and next register values; outputs take the value of the state being entered
    always_comb begin
        w_state_nxt    = r_state;
        w_rd_ptr_nxt   = r_rd_ptr;
        w_count_nxt    = r_count;
        w_csum_nxt     = r_csum;
        w_tx_data_nxt  = r_tx_data;
        w_tx_valid_nxt = r_tx_valid;
        w_busy_nxt     = r_busy;
        w_done_nxt     = 1'b0;
        w_mem_addr_nxt = r_mem_addr;

        case (r_state)
            RD_IDLE: begin
                w_busy_nxt     = 1'b0;
                w_tx_valid_nxt = 1'b0;
                if (start) begin
                    w_rd_ptr_nxt   = trig_offset + PTR_HALF;
                    w_count_nxt    = '0;
                    w_csum_nxt     = '0;
                    w_tx_data_nxt  = HDR0;
                    w_tx_valid_nxt = 1'b1;
                    w_busy_nxt     = 1'b1;
                    w_state_nxt    = RD_HDR0;
                end
            end
            RD_HDR0: begin
                if (w_xfer) begin
                    w_tx_data_nxt = HDR1;
                    w_state_nxt   = RD_HDR1;
                end
            end
            RD_HDR1: begin
                if (w_xfer) begin
                    w_tx_valid_nxt = 1'b0;
                    w_mem_addr_nxt = r_rd_ptr;
                    w_state_nxt    = RD_FETCH;
                end
            end
            RD_FETCH: begin
                w_state_nxt = RD_LOAD;
            end
            RD_LOAD: begin
                // RAM data for the address issued in FETCH is valid this cycle
                w_tx_data_nxt  = mem_rd_data;
                w_tx_valid_nxt = 1'b1;
                w_state_nxt    = RD_SEND;
            end
            RD_SEND: begin
                if (w_xfer) begin
                    w_csum_nxt   = w_csum_add;
                    w_rd_ptr_nxt = r_rd_ptr + ONE;
                    w_count_nxt  = r_count + ONE;
                    if (r_count == LAST_CNT) begin
                        w_tx_data_nxt = w_csum_add;
                        w_state_nxt   = RD_CSUM;
                    end else begin
                        w_tx_valid_nxt = 1'b0;
                        w_mem_addr_nxt = r_rd_ptr + ONE;
                        w_state_nxt    = RD_FETCH;
                    end
                end
            end
            RD_CSUM: begin
                if (w_xfer) begin
                    w_tx_valid_nxt = 1'b0;
                    w_busy_nxt     = 1'b0;
                    w_done_nxt     = 1'b1;
                    w_state_nxt    = RD_FINISH;
                end
            end
            RD_FINISH: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = RD_IDLE;
            end
            default: begin
                w_state_nxt = RD_IDLE;
            end
        endcase
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign mem_addr = r_mem_addr;
    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;

endmodule

// File: tb/tb_sample_readout.sv
// Directed bench for sample_readout: frame content, latency, stalls,
// ignored starts and mid-frame reset.
module tb_sample_readout;

    logic       clk_50mhz = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [7:0] trig_offset = 8'h00;
    logic       busy;
    logic       done;
    logic [7:0] mem_addr;
    logic [7:0] mem_rd_data;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;

    logic [7:0] ram [0:255];
    logic [7:0] rx_q [$];
    int         done_cnt = 0;
    int         stab_err = 0;
    int         stall_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    int passed = 0;
    int total  = 0;

    sample_readout dut (
        .clk_50mhz   (clk_50mhz),
        .reset       (reset),
        .start       (start),
        .trig_offset (trig_offset),
        .busy        (busy),
        .done        (done),
        .mem_addr    (mem_addr),
        .mem_rd_data (mem_rd_data),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready)
    );

    always #10 clk_50mhz = ~clk_50mhz;

    // Synchronous capture RAM, one cycle read latency
    always @(posedge clk_50mhz) mem_rd_data <= ram[mem_addr];

    // Transfer monitor, sampled mid-cycle
    always @(negedge clk_50mhz) begin
        if (!reset) begin
            if (tx_valid && tx_ready) rx_q.push_back(tx_data);
            if (done) done_cnt = done_cnt + 1;
            if (tx_valid && !tx_ready) stall_cnt = stall_cnt + 1;
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stab_err = stab_err + 1;
        end
        prev_stall = tx_valid && !tx_ready && !reset;
        prev_data  = tx_data;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic fill_ram(input int mode);
        for (int i = 0; i < 256; i++) begin
            case (mode)
                0:       ram[i] = 8'(i);
                1:       ram[i] = 8'(i * 37 + 11) ^ 8'(i >> 3);
                default: ram[i] = 8'($urandom_range(0, 255));
            endcase
        end
    endtask

    function automatic logic [7:0] get_byte(input int idx);
        if (idx < rx_q.size()) return rx_q[idx];
        return 8'hxx;
    endfunction

    function automatic logic [7:0] ram_sum();
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 256; i++) s = s + ram[i];
        return s;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [7:0] trig, input int k);
        if (k == 0) return 8'hA5;
        if (k == 1) return 8'h5A;
        if (k == 258) return ram_sum();
        return ram[8'(trig + 8'd128 + 8'(k - 2))];
    endfunction

    task automatic pulse_start(input logic [7:0] t);
        @(posedge clk_50mhz); #1;
        trig_offset = t;
        start = 1'b1;
        @(posedge clk_50mhz); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int base, input bit rnd);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk_50mhz); #1;
            if (rnd) tx_ready = 1'($urandom_range(0, 1));
            if (done_cnt > base) begin
                seen = 1'b1;
                break;
            end
        end
        tx_ready = 1'b1;
        repeat (4) @(posedge clk_50mhz);
        #1;
        total++;
        if (!seen) $display("FAIL %s_timeout: got no done, want done within 6000 cycles", name);
        else passed++;
    endtask

    task automatic check_frame(input string name, input logic [7:0] trig, input int qbase);
        int n, bad, first;
        logic [7:0] g, e, fg, fe, sum;
        n = rx_q.size() - qbase;
        total++;
        if (n != 259) $display("FAIL %s_len: got %0d bytes, want 259", name, n);
        else passed++;
        bad = 0; first = -1; fg = 8'h00; fe = 8'h00;
        for (int k = 0; k < 259; k++) begin
            e = exp_byte(trig, k);
            g = get_byte(qbase + k);
            if (g !== e) begin
                if (first < 0) begin first = k; fg = g; fe = e; end
                bad++;
            end
        end
        total++;
        if (bad != 0) $display("FAIL %s_bytes: %0d wrong, first at %0d got %02h want %02h", name, bad, first, fg, fe);
        else passed++;
        sum = ram_sum();
        total++;
        if (get_byte(qbase + 258) !== sum) $display("FAIL %s_csum: got %02h want %02h", name, get_byte(qbase + 258), sum);
        else passed++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        #1;
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
        total++; if (tx_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", tx_valid); else passed++;
        total++; if (tx_data !== 8'h00) $display("FAIL reset_data: got %02h want 00", tx_data); else passed++;
        total++; if (mem_addr !== 8'h00) $display("FAIL reset_addr: got %02h want 00", mem_addr); else passed++;
        reset = 1'b0;
        tx_ready = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL idle_ready_valid: got %b want 0", tx_valid); else passed++;
    endtask

    // trig 0x00, RAM[i]=i, ready held high: cycle-exact latency then full frame
    task automatic test_latency();
        int qb, db;
        fill_ram(0);
        tx_ready = 1'b1;
        qb = rx_q.size(); db = done_cnt;
        pulse_start(8'h00);
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'hA5) $display("FAIL lat_hdr0: got v=%b d=%02h want v=1 d=a5", tx_valid, tx_data); else passed++;
        total++; if (busy !== 1'b1) $display("FAIL lat_busy: got %b want 1", busy); else passed++;
        @(posedge clk_50mhz); #1;
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h5A) $display("FAIL lat_hdr1: got v=%b d=%02h want v=1 d=5a", tx_valid, tx_data); else passed++;
        @(posedge clk_50mhz); #1;
        total++; if (tx_valid !== 1'b0 || mem_addr !== 8'h80) $display("FAIL lat_fetch: got v=%b a=%02h want v=0 a=80", tx_valid, mem_addr); else passed++;
        @(posedge clk_50mhz); #1;
        total++; if (tx_valid !== 1'b0) $display("FAIL lat_load: got v=%b want 0", tx_valid); else passed++;
        @(posedge clk_50mhz); #1;
        total++; if (tx_valid !== 1'b1 || tx_data !== 8'h80) $display("FAIL lat_sample0: got v=%b d=%02h want v=1 d=80", tx_valid, tx_data); else passed++;
        wait_done("lat", db, 1'b0);
        check_frame("lat", 8'h00, qb);
        total++; if (get_byte(qb + 129) !== 8'hFF) $display("FAIL lat_s127: got %02h want ff", get_byte(qb + 129)); else passed++;
        total++; if (get_byte(qb + 130) !== 8'h00) $display("FAIL lat_s128: got %02h want 00", get_byte(qb + 130)); else passed++;
        total++; if (get_byte(qb + 257) !== 8'h7F) $display("FAIL lat_s255: got %02h want 7f", get_byte(qb + 257)); else passed++;
        total++; if (get_byte(qb + 258) !== 8'h80) $display("FAIL lat_csum_const: got %02h want 80", get_byte(qb + 258)); else passed++;
        total++; if (done_cnt - db != 1) $display("FAIL lat_done_cnt: got %0d want 1", done_cnt - db); else passed++;
        total++; if (busy !== 1'b0) $display("FAIL lat_busy_end: got %b want 0", busy); else passed++;
    endtask

    // trig 0x7F: oldest sample is 0xFF, trigger sample at index 128
    task automatic test_wrap();
        int qb, db;
        fill_ram(0);
        tx_ready = 1'b1;
        qb = rx_q.size(); db = done_cnt;
        pulse_start(8'h7F);
        wait_done("wrap", db, 1'b0);
        total++; if (get_byte(qb + 2) !== 8'hFF) $display("FAIL wrap_first: got %02h want ff", get_byte(qb + 2)); else passed++;
        total++; if (get_byte(qb + 3) !== 8'h00) $display("FAIL wrap_second: got %02h want 00", get_byte(qb + 3)); else passed++;
        total++; if (get_byte(qb + 130) !== 8'h7F) $display("FAIL wrap_trig: got %02h want 7f", get_byte(qb + 130)); else passed++;
        check_frame("wrap", 8'h7F, qb);
    endtask

    // Random ready stalls: data must hold while stalled
    task automatic test_stalls();
        int qb, db, eb, sb;
        fill_ram(1);
        tx_ready = 1'b0;
        qb = rx_q.size(); db = done_cnt; eb = stab_err; sb = stall_cnt;
        pulse_start(8'h3C);
        wait_done("stall", db, 1'b1);
        check_frame("stall", 8'h3C, qb);
        total++; if (stab_err != eb) $display("FAIL stall_stable: got %0d violations want 0", stab_err - eb); else passed++;
        total++; if (stall_cnt - sb < 20) $display("FAIL stall_seen: got %0d stall cycles want >=20", stall_cnt - sb); else passed++;
        total++; if (done_cnt - db != 1) $display("FAIL stall_done_cnt: got %0d want 1", done_cnt - db); else passed++;
    endtask

    // Start during SEND and during FINISH are both ignored
    task automatic test_double_start();
        int qb, db;
        bit injected, fin_seen;
        fill_ram(2);
        tx_ready = 1'b1;
        qb = rx_q.size(); db = done_cnt;
        pulse_start(8'h10);
        injected = 1'b0; fin_seen = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            @(posedge clk_50mhz); #1;
            start = 1'b0;
            if (done) begin
                trig_offset = 8'h99;
                start = 1'b1;
                fin_seen = 1'b1;
                break;
            end
            if (!injected && tx_valid && (rx_q.size() - qb) >= 50) begin
                trig_offset = 8'h40;
                start = 1'b1;
                injected = 1'b1;
            end
        end
        @(posedge clk_50mhz); #1;
        start = 1'b0;
        total++; if (!fin_seen) $display("FAIL dbl_timeout: got no done, want done within 6000 cycles"); else passed++;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL dbl_fin_start: got busy=%b v=%b want 0 0", busy, tx_valid); else passed++;
        repeat (3) @(posedge clk_50mhz);
        #1;
        total++; if (busy !== 1'b0 || tx_valid !== 1'b0) $display("FAIL dbl_idle: got busy=%b v=%b want 0 0", busy, tx_valid); else passed++;
        total++; if (done_cnt - db != 1) $display("FAIL dbl_done_cnt: got %0d want 1", done_cnt - db); else passed++;
        check_frame("dbl", 8'h10, qb);
    endtask

    // Reset after 40 samples aborts the frame; a new start still works
    task automatic test_reset_mid();
        int qb, db, qs;
        bit reached;
        fill_ram(0);
        tx_ready = 1'b1;
        qb = rx_q.size(); db = done_cnt;
        pulse_start(8'h20);
        reached = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk_50mhz); #1;
            if (rx_q.size() - qb >= 42) begin
                reached = 1'b1;
                break;
            end
        end
        total++; if (!reached) $display("FAIL rmid_reach: got %0d bytes want 42", rx_q.size() - qb); else passed++;
        reset = 1'b1;
        @(posedge clk_50mhz); #1;
        total++; if (tx_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_abort: got v=%b busy=%b done=%b want 0 0 0", tx_valid, busy, done); else passed++;
        reset = 1'b0;
        qs = rx_q.size();
        repeat (20) @(posedge clk_50mhz);
        #1;
        total++; if (rx_q.size() != qs || done_cnt != db) $display("FAIL rmid_quiet: got %0d bytes %0d dones want 0 0", rx_q.size() - qs, done_cnt - db); else passed++;
        fill_ram(1);
        qb = rx_q.size(); db = done_cnt;
        pulse_start(8'hC3);
        wait_done("rmid", db, 1'b0);
        check_frame("rmid", 8'hC3, qb);
    endtask

    initial begin
        test_reset();
        test_latency();
        test_wrap();
        test_stalls();
        test_double_start();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sample_readout.md
SAMPLE_READOUT -- requirements
Module: sample_readout

Interface
REQ-001 SHALL have parameter SAMPLE_DEPTH, default 8, address width of the capture memory (256 samples).
REQ-002 SHALL have parameter HDR0, default 8'hA5, first frame header byte.
REQ-003 SHALL have parameter HDR1, default 8'h5A, second frame header byte.
REQ-004 SHALL use one clock and a synchronous, active-high reset.
REQ-005 clk_50mhz  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 start  in  1  one-cycle pulse from the sampler's done; requests readout of a completed capture.
REQ-008 trig_offset  in  SAMPLE_DEPTH  memory address at which the trigger sample was written.
REQ-009 busy  out  1  high from the cycle after an accepted start until the frame ends.
REQ-010 done  out  1  one-cycle pulse after the checksum byte is accepted.
REQ-011 mem_addr  out  SAMPLE_DEPTH  registered read address to the capture memory.
REQ-012 mem_rd_data  in  8  synchronous RAM read data, valid 1 cycle after mem_addr.
REQ-013 tx_data  out  8  byte to the UART transmitter.
REQ-014 tx_valid  out  1  tx_data holds a byte for transfer.
REQ-015 tx_ready  in  1  transmitter accepts; a transfer occurs on a cycle with tx_valid && tx_ready.

Function
REQ-016 States SHALL be IDLE, HDR0, HDR1, FETCH, LOAD, SEND, CSUM, FINISH.
REQ-017 IDLE: on start, latch rd_ptr = trig_offset + 2^(SAMPLE_DEPTH-1) (mod 2^SAMPLE_DEPTH), clear sample count and checksum, go to HDR0; start SHALL be ignored in every other state.
REQ-018 HDR0/HDR1: drive tx_data = HDR0/HDR1 with tx_valid=1; advance only on transfer; HDR1 transfer goes to FETCH.
REQ-019 FETCH: mem_addr = rd_ptr for one cycle; goes to LOAD.
REQ-020 LOAD: register mem_rd_data into tx_data; goes to SEND; tx_valid SHALL be 0 in FETCH and LOAD.
REQ-021 SEND: tx_valid=1; on transfer add the byte to the 8-bit checksum (mod 256), increment rd_ptr (wrap 255->0), and increment the count; after the 2^SAMPLE_DEPTH-th sample go to CSUM, otherwise go to FETCH.
REQ-022 CSUM: drive tx_data = checksum, tx_valid=1; on transfer go to FINISH.
REQ-023 FINISH: done=1 for exactly one cycle, busy=0, go to IDLE.
REQ-024 A frame SHALL be HDR0, HDR1, 256 samples from oldest to newest, then checksum (259 bytes); the trigger sample SHALL be frame sample index 128.
REQ-025 tx_data SHALL remain stable while tx_valid && !tx_ready; tx_valid SHALL never drop without a transfer except on reset.
REQ-026 tx_ready asserted while tx_valid=0 SHALL have no effect.
REQ-027 Latency: start at cycle N -> tx_valid=1 with HDR0 at cycle N+1; each sample byte SHALL be presented 3 cycles after the previous byte's transfer.
REQ-028 A start coincident with the FINISH cycle SHALL be ignored; the earliest accepted start is the cycle after done.
REQ-029 The checksum SHALL cover sample bytes only, not headers.

Reset
REQ-030 When reset is high at a rising edge: state=IDLE, busy=0, done=0, tx_valid=0, tx_data=0, mem_addr=0, checksum=0, count=0.
REQ-031 Reset SHALL take priority over start and tx_ready; a reset mid-frame SHALL abort the frame with no done pulse, and no further bytes SHALL be sent until a new start.

Structure
REQ-032 SAMPLE_DEPTH, HDR0/HDR1 defaults, and the readout state enum typedef SHALL live in the shared package oscilo_pkg, which the sampler also uses.
REQ-033 The block SHALL be a single module; a sub-module is not natural at this size.

Verification
REQ-034 trig_offset=0x00, RAM[i]=i, tx_ready held at 1 -> bytes A5,5A,80..FF,00..7F,80; done exactly once.
REQ-035 trig_offset=0x7F, RAM[i]=i -> first sample 0xFF, frame sample index 128 = 0x7F; the address wraps 0xFF->0x00 without a glitch.
REQ-036 Random tx_ready stalls (about 50% duty) -> tx_data stable under every stall; 259 transfers; checksum equals the sum of sample bytes mod 256.
REQ-037 Second start pulse during SEND -> ignored; exactly one frame and one done.
REQ-038 Reset asserted at sample 40 -> next cycle tx_valid=0, busy=0, no done; a new start then produces a complete correct frame.
REQ-039 start at cycle 10 with tx_ready=1 -> HDR0 transfer at cycle 11, HDR1 at cycle 12, first sample tx_valid at cycle 15.
